// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clk to a pixel tick, runs h/v counters, decodes syncs and gates colour.
// Sync and colour outputs are registered on the tick, one pixel behind pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_tick,
  output logic        video_on,
  output logic        frame_start,
  output logic        h_sync,
  output logic        v_sync,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [3:0]  r_div;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic [11:0] r_rgb;

  logic        w_tick;
  logic        w_h_end;
  logic        w_video;
  logic        w_hs_act;
  logic        w_vs_act;

  // Gating with rst keeps the tick low in reset even when CLK_DIV=1 makes div==max permanently.
  assign w_tick   = (r_div == DIV_MAX) && !rst;
  assign w_h_end  = (r_h_cnt == H_MAX);
  assign w_video  = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_act = (r_h_cnt >= HS_LO) && (r_h_cnt <= HS_HI);
  assign w_vs_act = (r_v_cnt >= VS_LO) && (r_v_cnt <= VS_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_rgb   <= 12'h000;
    end else begin
      r_div <= (r_div == DIV_MAX) ? 4'd0 : r_div + 4'd1;
      if (w_tick) begin
        if (w_h_end) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
        r_hs  <= !w_hs_act;
        r_vs  <= !w_vs_act;
        r_rgb <= w_video ? rgb : 12'h000;
      end
    end
  end

  assign pixel_x     = r_h_cnt;
  assign pixel_y     = r_v_cnt;
  assign pixel_tick  = w_tick;
  assign video_on    = w_video;
  assign frame_start = w_tick && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign Red         = r_rgb[11:8];
  assign Green       = r_rgb[7:4];
  assign Blue        = r_rgb[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-timing instance checked edge by edge against an arithmetic model,
// plus a CLK_DIV=1 default-timing instance checked over two lines.
module tb_vga_sync_gen;

  localparam int D = 3, HD = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VD = 6, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HD + HF + HSW + HB;
  localparam int VT = VD + VF + VSW + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        tick;
    logic        fs;
    logic        von;
    logic        hs;
    logic        vs;
    logic [11:0] col;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] rgb = 12'h000;
  logic [9:0]  px, py;
  logic        tick, von, fs, hs, vs;
  logic [3:0]  red, grn, blu;

  logic        rst1 = 1'b1;
  logic [9:0]  px1, py1;
  logic        tick1, von1, fs1, hs1, vs1;
  logic [3:0]  red1, grn1, blu1;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) u_dut (
    .clk(clk), .rst(rst), .rgb(rgb),
    .pixel_x(px), .pixel_y(py), .pixel_tick(tick), .video_on(von),
    .frame_start(fs), .h_sync(hs), .v_sync(vs),
    .Red(red), .Green(grn), .Blue(blu)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst1), .rgb(12'h5A3),
    .pixel_x(px1), .pixel_y(py1), .pixel_tick(tick1), .video_on(von1),
    .frame_start(fs1), .h_sync(hs1), .v_sync(vs1),
    .Red(red1), .Green(grn1), .Blue(blu1)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  logic mon_en = 1'b0;
  logic d1_done = 1'b0;
  int   e = 0;
  logic [11:0] cap = 12'h000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_act(input int p);
    return ((p % HT) < HD) && ((p / HT) < VD);
  endfunction

  function automatic obs_t rst_obs();
    obs_t o;
    o = '0;
    o.von = 1'b1;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    return o;
  endfunction

  // State after the e-th clk edge since reset release, derived from elapsed ticks.
  function automatic obs_t model(input int edges, input logic [11:0] c);
    obs_t o;
    int n, p, q;
    n      = edges / D;
    p      = n % FT;
    o.x    = 10'(p % HT);
    o.y    = 10'(p / HT);
    o.tick = ((edges % D) == D - 1);
    o.fs   = o.tick && (p == 0);
    o.von  = in_act(p);
    if (n == 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      q    = (n - 1) % FT;
      o.hs = !(((q % HT) >= HD + HF) && ((q % HT) < HD + HF + HSW));
      o.vs = !(((q / HT) >= VD + VF) && ((q / HT) < VD + VF + VSW));
    end
    o.col = c;
    return o;
  endfunction

  task automatic cmp_obs(input string tag, input obs_t ex);
    chk({tag, "_pixel_x"}, int'(px), int'(ex.x));
    chk({tag, "_pixel_y"}, int'(py), int'(ex.y));
    chk({tag, "_pixel_tick"}, int'(tick), int'(ex.tick));
    chk({tag, "_frame_start"}, int'(fs), int'(ex.fs));
    chk({tag, "_video_on"}, int'(von), int'(ex.von));
    chk({tag, "_h_sync"}, int'(hs), int'(ex.hs));
    chk({tag, "_v_sync"}, int'(vs), int'(ex.vs));
    chk({tag, "_rgb_out"}, int'({red, grn, blu}), int'(ex.col));
  endtask

  task automatic hold_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst = 1'b1;
      rgb = 12'($urandom);
      e   = 0;
      cap = 12'h000;
      mon_en = 1'b1;
      exp_q.push_back(rst_obs());
    end
  endtask

  task automatic run(input int ncyc);
    int q;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst = 1'b0;
      rgb = ($urandom_range(0, 3) == 0) ? 12'hABC : 12'($urandom);
      e++;
      if ((e % D) == 0) begin
        q   = (e / D - 1) % FT;
        cap = in_act(q) ? rgb : 12'h000;
      end
      exp_q.push_back(model(e, cap));
    end
  endtask

  always begin
    obs_t ex;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty got 0 expected 1 at %0t", $time);
      end else begin
        ex = exp_q.pop_front();
        cmp_obs("edge", ex);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 cmp_obs("async_rst_t0", rst_obs());
    hold_reset(3);
    run(2 * FT * D + 300 * D + 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 cmp_obs("async_rst_mid", rst_obs());
    e   = 0;
    cap = 12'h000;
    exp_q.push_back(rst_obs());
    hold_reset(2);
    run(FT * D + 20);
    @(posedge clk);
    #2 mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
    wait (d1_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // CLK_DIV=1 with default 800x525 timing: tick always high, 800-clk lines, 96-clk h_sync.
  initial begin
    int lo, tk;
    lo = 0;
    tk = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("d1_tick_in_reset", int'(tick1), 0);
    chk("d1_hsync_in_reset", int'(hs1), 1);
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 1; i <= 1600; i++) begin
      @(posedge clk);
      #1;
      if (!hs1) lo++;
      if (tick1) tk++;
      if (i == 799) chk("d1_x_799", int'(px1), 799);
      if (i == 800) begin
        chk("d1_x_wrap", int'(px1), 0);
        chk("d1_y_after_line", int'(py1), 1);
      end
    end
    chk("d1_hsync_low_clks", lo, 192);
    chk("d1_tick_count", tk, 1600);
    d1_done = 1'b1;
  end

endmodule
